// File: rtl/lsu_ctrl.sv
// lsu_ctrl: big-endian load/store controller that splits misaligned halves/words into byte transactions
module lsu_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t r_state;
    logic r_we, r_err;
    logic [2:0] r_func;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0] r_wdata, r_asm;
    logic [1:0] r_cnt;
    logic w_ill, w_split, w_last, w_acc;
    logic [1:0] w_top, w_sel;
    logic [31:0] w_ext, w_rd;
    assign w_ill = req_we ? (req_func[2] || req_func[1:0] == 2'b11) : (req_func[1:0] == 2'b11 || req_func[2:1] == 2'b11);
    assign w_split = (r_func[1:0] == 2'b01 && r_addr[0]) || (r_func[1:0] == 2'b10 && r_addr[1:0] != 2'b00);
    assign w_top = r_func[1] ? 2'd3 : 2'd1;
    assign w_last = !w_split || r_cnt == w_top;
    assign w_sel = w_top - r_cnt;
    assign w_acc = r_state == ACCESS;
    assign w_rd = r_func[1] ? mem_rdata : r_func[0] ? {16'b0, mem_rdata[31:16]} : {24'b0, mem_rdata[31:24]};
    assign w_ext = r_func[1] ? r_asm : r_func[0] ? {{16{r_asm[15] & ~r_func[2]}}, r_asm[15:0]} : {{24{r_asm[7] & ~r_func[2]}}, r_asm[7:0]};
    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_err = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_ext : 32'b0;
    assign mem_read = w_acc && !r_we && !rst;
    assign mem_write = w_acc && r_we && !rst;
    assign mem_func = (w_acc && !w_split) ? {1'b0, r_func[1:0]} : 3'b0;
    assign mem_addr = w_acc ? r_addr + ADDR_W'(r_cnt) : '0;
    assign mem_wdata = !w_acc ? 32'b0 : w_split ? {24'b0, r_wdata[{w_sel, 3'b000} +: 8]} : r_wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= 2'd0;
            r_asm <= 32'b0;
            r_we <= 1'b0;
            r_err <= 1'b0;
            r_func <= 3'b0;
            r_addr <= '0;
            r_wdata <= 32'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we <= req_we;
                    r_func <= req_func;
                    r_addr <= req_addr;
                    r_wdata <= req_wdata;
                    r_cnt <= 2'd0;
                    r_asm <= 32'b0;
                    r_err <= w_ill;
                    r_state <= w_ill ? RESP : ACCESS;
                end
                ACCESS: begin
                    if (!r_we && w_split) r_asm[{w_sel, 3'b000} +: 8] <= mem_rdata[31:24];
                    else if (!r_we) r_asm <= w_rd;
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
